// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 scan-code constants, event layout and decoder state type.
package ps2_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_BAT      = 8'hAA;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_ECHO     = 8'hEE;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] FAKE_RSHIFT = 8'h59;
  localparam logic [7:0] PAUSE_CODE  = 8'h77;

  localparam int unsigned EVT_BRK = 9;
  localparam int unsigned EVT_EXT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  // Keyboard status/protocol bytes that never represent a key.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF) || (b == SC_BAT) || (b == SC_ACK) ||
           (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == FAKE_LSHIFT) || (b == FAKE_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO with explicit occupancy register.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     wr_ok_o,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = rd_en_i && !empty_o;
  // A pop frees the slot the same cycle, so a full FIFO still accepts.
  assign do_push = wr_en_i && (!full_o || do_pop);
  assign wr_ok_o = do_push;

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 Set-2 prefix sequences into 10-bit key events and queues them.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   frame_err,
  output logic                   evt_valid,
  output logic [9:0]             evt_data,
  input  logic                   evt_ready,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow,
  input  logic                   ovf_clear,
  output logic [7:0]             last_code
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e    state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    last_code_q, last_code_d;

  logic          push;
  logic [9:0]    evt_d;
  logic          wr_ok;
  logic          fifo_full, fifo_empty;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    push    = 1'b0;
    evt_d   = '0;
    if (frame_err) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
    end else if (byte_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (byte_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (byte_data == SC_BRK) begin
            state_d = ST_BRK;
          end else if (byte_data == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = 3'd7;
          end else if (!is_status_byte(byte_data)) begin
            push  = 1'b1;
            evt_d = {1'b0, 1'b0, byte_data};
          end
        end
        ST_EXT: begin
          if (byte_data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            push    = !is_fake_shift(byte_data);
            evt_d   = {1'b0, 1'b1, byte_data};
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          push    = 1'b1;
          evt_d   = {1'b1, 1'b0, byte_data};
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          push    = !is_fake_shift(byte_data);
          evt_d   = {1'b1, 1'b1, byte_data};
        end
        ST_SKIP: begin
          // Pause is E1 plus seven fixed bytes; the content is not checked.
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = '0;
            push    = 1'b1;
            evt_d   = {1'b0, 1'b1, PAUSE_CODE};
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (push && !wr_ok) overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
    last_code_d = last_code_q;
    if (wr_ok && !evt_d[EVT_BRK]) last_code_d = evt_d[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      tmo_q       <= '0;
      overflow_q  <= 1'b0;
      last_code_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      overflow_q  <= overflow_d;
      last_code_q <= last_code_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH (10),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (push),
    .wr_data_i (evt_d),
    .wr_ok_o   (wr_ok),
    .rd_en_i   (evt_ready),
    .rd_data_o (evt_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (evt_count)
  );

  assign evt_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign last_code = last_code_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
